// File: rtl/fp_add_align.sv
// Alignment stage ahead of the mantissa adder: orders two IEEE-754 operands by
// magnitude and right-shifts the smaller significand one bit per cycle.
module fp_add_align #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EW+MW:0]      op_a,
  input  logic [EW+MW:0]      op_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_big,
  output logic                sign_small,
  output logic                eff_sub,
  output logic [EW-1:0]       exp_out,
  output logic [MW+3:0]       mant_big,
  output logic [MW+3:0]       mant_small,
  output logic                is_special
);

  localparam int W  = MW + 4;
  localparam int CW = $clog2(W);
  localparam logic [EW-1:0] EXP_ONES  = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_ZERO  = {EW{1'b0}};
  localparam logic [EW-1:0] EXP_DENRM = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] SHIFT_MAX = EW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            sign_big_q;
  logic            sign_small_q;
  logic            eff_sub_q;
  logic [EW-1:0]   exp_q;
  logic [W-1:0]    mant_big_q;
  logic [W-1:0]    mant_small_q;
  logic            special_q;
  logic [CW-1:0]   cnt_q;

  logic [EW-1:0]   a_exp, b_exp, a_exp_eff, b_exp_eff;
  logic [EW-1:0]   big_exp, small_exp, exp_diff;
  logic [W-1:0]    a_sig, b_sig;
  logic            a_sign, b_sign, a_is_big, special;
  logic [CW-1:0]   cnt_d;
  logic [W-1:0]    mant_small_d;

  // Unpack both operands, pick the larger magnitude and derive the shift count.
  always_comb begin
    a_sign    = op_a[EW+MW];
    b_sign    = op_b[EW+MW];
    a_exp     = op_a[EW+MW-1:MW];
    b_exp     = op_b[EW+MW-1:MW];
    a_exp_eff = (a_exp == EXP_ZERO) ? EXP_DENRM : a_exp;
    b_exp_eff = (b_exp == EXP_ZERO) ? EXP_DENRM : b_exp;
    a_sig     = {(a_exp != EXP_ZERO), op_a[MW-1:0], 3'b000};
    b_sig     = {(b_exp != EXP_ZERO), op_b[MW-1:0], 3'b000};
    // Ties on exponent fall back to significand; full ties keep A as big.
    a_is_big  = (a_exp_eff > b_exp_eff) ||
                ((a_exp_eff == b_exp_eff) && (a_sig >= b_sig));
    big_exp   = a_is_big ? a_exp_eff : b_exp_eff;
    small_exp = a_is_big ? b_exp_eff : a_exp_eff;
    exp_diff  = big_exp - small_exp;
    special   = (a_exp == EXP_ONES) || (b_exp == EXP_ONES);
    if (special) begin
      cnt_d = CNT_ZERO;
    end else if (exp_diff > SHIFT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = exp_diff[CW-1:0];
    end
    mant_small_d = {1'b0, mant_small_q[W-1:2], mant_small_q[1] | mant_small_q[0]};
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      eff_sub_q    <= 1'b0;
      exp_q        <= EXP_ZERO;
      mant_big_q   <= {W{1'b0}};
      mant_small_q <= {W{1'b0}};
      special_q    <= 1'b0;
      cnt_q        <= CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_big_q   <= a_is_big ? a_sign : b_sign;
            sign_small_q <= a_is_big ? b_sign : a_sign;
            eff_sub_q    <= a_sign ^ b_sign;
            exp_q        <= big_exp;
            mant_big_q   <= a_is_big ? a_sig : b_sig;
            mant_small_q <= a_is_big ? b_sig : a_sig;
            special_q    <= special;
            cnt_q        <= cnt_d;
            in_ready_q   <= 1'b0;
            if (cnt_d == CNT_ZERO) begin
              state_q     <= OUT;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ALIGN;
            end
          end
        end
        ALIGN: begin
          mant_small_q <= mant_small_d;
          cnt_q        <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign eff_sub    = eff_sub_q;
  assign exp_out    = exp_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign is_special = special_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: expected alignments are queued at accept
// and compared, with latency, when out_valid appears.
module tb_fp_add_align;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_big, sign_small, eff_sub, is_special;
  logic [7:0]  exp_out;
  logic [26:0] mant_big, mant_small;
  logic [65:0] dut_vec;

  typedef struct {
    logic [65:0] vec;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fp_add_align #(.EW(8), .MW(23)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .eff_sub(eff_sub),
    .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small),
    .is_special(is_special)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign dut_vec = {sign_big, sign_small, eff_sub, exp_out, mant_big, mant_small, is_special};

  // Reference: one barrel shift with a sticky OR of every bit shifted out.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [7:0]  ea, eb, xa, xb;
    logic [26:0] ma, mb, mbig, msm, mask;
    logic        abig, spec, sbg, ssm;
    int          sh;
    ea   = a[30:23];
    eb   = b[30:23];
    xa   = (ea == 8'd0) ? 8'd1 : ea;
    xb   = (eb == 8'd0) ? 8'd1 : eb;
    ma   = {(ea != 8'd0), a[22:0], 3'b000};
    mb   = {(eb != 8'd0), b[22:0], 3'b000};
    abig = (xa > xb) || ((xa == xb) && (ma >= mb));
    spec = (ea == 8'hFF) || (eb == 8'hFF);
    sh   = abig ? (int'(xa) - int'(xb)) : (int'(xb) - int'(xa));
    if (sh > 26) sh = 26;
    if (spec) sh = 0;
    mbig = abig ? ma : mb;
    msm  = abig ? mb : ma;
    sbg  = abig ? a[31] : b[31];
    ssm  = abig ? b[31] : a[31];
    mask = (27'd1 << sh) - 27'd1;
    msm  = (msm >> sh) | {26'd0, |(msm & mask)};
    r.vec = {sbg, ssm, sbg ^ ssm, (abig ? xa : xb), mbig, msm, spec};
    r.lat = sh + 1;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h3E800000;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (dut_vec !== 66'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", dut_vec); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_capture: got %b want 0", out_valid); end
    // out_ready with nothing pending must not disturb IDLE
    release_out();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_out_ready: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_equal_exp();
    exp_t e; int lat;
    drive(32'h3F800000, 32'h3F800000);
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL eq_lat: got %0d want 1", lat); end
    n_cmp++; if (dut_vec !== e.vec) begin n_err++; $display("FAIL eq_vec: got %h want %h", dut_vec, e.vec); end
    n_cmp++; if (mant_small !== 27'h4000000 || exp_out !== 8'h7F || eff_sub !== 1'b0) begin
      n_err++; $display("FAIL eq_fields: got ms=%h e=%h sub=%b want 4000000/7f/0", mant_small, exp_out, eff_sub); end
    release_out();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL eq_handshake: got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_short_shift();
    exp_t e; int lat;
    drive(32'h3F800000, 32'h3E800000);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL short_busy: got %b want 0", in_ready); end
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (lat !== 3 || lat !== e.lat) begin n_err++; $display("FAIL short_lat: got %0d want 3", lat); end
    n_cmp++; if (dut_vec !== e.vec) begin n_err++; $display("FAIL short_vec: got %h want %h", dut_vec, e.vec); end
    n_cmp++; if (mant_big !== 27'h4000000 || mant_small !== 27'h1000000) begin
      n_err++; $display("FAIL short_mant: got %h/%h want 4000000/1000000", mant_big, mant_small); end
    release_out();
  endtask

  task automatic test_clamp();
    exp_t e; int lat;
    drive(32'h3F800000, 32'h30800000);
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (lat !== 27) begin n_err++; $display("FAIL clamp_lat: got %0d want 27", lat); end
    n_cmp++; if (mant_small !== 27'h0000001) begin n_err++; $display("FAIL clamp_sticky: got %h want 0000001", mant_small); end
    n_cmp++; if (dut_vec !== e.vec) begin n_err++; $display("FAIL clamp_vec: got %h want %h", dut_vec, e.vec); end
    release_out();
  endtask

  task automatic test_swap_sign();
    exp_t e; int lat;
    drive(32'h3E800000, 32'hBF800000);
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (sign_big !== 1'b1 || sign_small !== 1'b0 || eff_sub !== 1'b1) begin
      n_err++; $display("FAIL swap_sign: got %b%b%b want 101", sign_big, sign_small, eff_sub); end
    n_cmp++; if (mant_big !== 27'h4000000 || mant_small !== 27'h1000000) begin
      n_err++; $display("FAIL swap_mant: got %h/%h want 4000000/1000000", mant_big, mant_small); end
    n_cmp++; if (dut_vec !== e.vec || lat !== e.lat) begin
      n_err++; $display("FAIL swap_vec: got %h lat %0d want %h lat %0d", dut_vec, lat, e.vec, e.lat); end
    release_out();
  endtask

  task automatic test_backpressure();
    exp_t e; int lat;
    drive(32'h40400000, 32'h3F000000);
    wait_out(lat); e = sb_q.pop_front();
    op_a = 32'hC1200000; op_b = 32'h3DCCCCCD; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (dut_vec !== e.vec || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got %h vld=%b rdy=%b want %h 1/0", i, dut_vec, out_valid, in_ready, e.vec); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    sb_q.push_back(model(op_a, op_b));
    tick(); in_valid = 1'b0;
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (dut_vec !== e.vec || lat !== e.lat) begin
      n_err++; $display("FAIL bp_next: got %h lat %0d want %h lat %0d", dut_vec, lat, e.vec, e.lat); end
    release_out();
  endtask

  task automatic test_reset_mid_align_special();
    exp_t e; int lat;
    drive(32'h3F800000, 32'h30800000);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    void'(sb_q.pop_front());
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_vec !== 66'd0) begin
      n_err++; $display("FAIL midrst: got vld=%b rdy=%b data=%h want 0/1/0", out_valid, in_ready, dut_vec); end
    for (int i = 0; i < 30; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %b want 0", out_valid); end
    drive(32'h7F800000, 32'h3F800000);
    wait_out(lat); e = sb_q.pop_front();
    n_cmp++; if (lat !== 1 || is_special !== 1'b1) begin
      n_err++; $display("FAIL special: got lat %0d sp=%b want 1/1", lat, is_special); end
    n_cmp++; if (dut_vec !== e.vec) begin n_err++; $display("FAIL special_vec: got %h want %h", dut_vec, e.vec); end
    release_out();
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      b[30:23] = a[30:23] ^ 8'($urandom_range(0, 31));
      if (i % 6 == 0) b[22:0] = 23'd0;
      if (i % 8 == 0) a[30:23] = 8'd0;
      if (i == 5) begin a = 32'd0; b = 32'h80000000; end
      drive(a, b);
      wait_out(lat); e = sb_q.pop_front();
      n_cmp++; if (dut_vec !== e.vec || lat !== e.lat) begin
        n_err++; $display("FAIL rand%0d a=%h b=%h: got %h lat %0d want %h lat %0d", i, a, b, dut_vec, lat, e.vec, e.lat); end
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
      release_out();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
    #1;
    test_reset();
    test_equal_exp();
    test_short_shift();
    test_clamp();
    test_swap_sign();
    test_backpressure();
    test_reset_mid_align_special();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
